// File: rtl/fmdll_pkg.sv
// Shared FMDLL types: lock sequencer states, clk_mid select codes and default code width.
package fmdll_pkg;

  localparam int CODE_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    SAR   = 2'd2,
    TRACK = 2'd3
  } lock_state_t;

  localparam logic [1:0] SEL_CLKOUT = 2'b00;
  localparam logic [1:0] SEL_CLKEXT = 2'b01;
  localparam logic [1:0] SEL_GATE   = 2'b10;

  function automatic logic [1:0] sel_of(input lock_state_t s);
    case (s)
      SAR:     return SEL_CLKEXT;
      TRACK:   return SEL_CLKOUT;
      default: return SEL_GATE;
    endcase
  endfunction

endpackage

// File: rtl/dcdl_settle_timer.sv
// Loadable down-counter: ready rises SETTLE cycles after a load, letting the delay line settle.
module dcdl_settle_timer #(
  parameter int SETTLE = 4
) (
  input  logic clk_ext,
  input  logic rst_n,
  input  logic load,
  output logic ready
);

  localparam int CW = $clog2(SETTLE + 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_ext) begin
    if (!rst_n)           cnt <= '0;
    else if (load)        cnt <= CW'(SETTLE);
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign ready = (cnt == '0);

endmodule

// File: rtl/dcdl_lock_ctrl.sv
// DCDL lock sequencer: gate, SAR acquisition, then +/-1 tracking with lock/unlock hysteresis.
// Build option: define DCDL_AUTO_RELOCK_EN to re-acquire automatically after a tracking bound hit.
module dcdl_lock_ctrl
  import fmdll_pkg::*;
#(
  parameter int CODE_W   = CODE_W_DEF,
  parameter int SETTLE   = 4,
  parameter int LOCK_CNT = 8
) (
  input  logic              clk_ext,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pd_valid,
  input  logic              pd_up,
  output logic [CODE_W-1:0] q_code,
  output logic [1:0]        sel,
  output logic              busy,
  output logic              locked,
  output logic              err
);

  localparam int BW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam logic [CODE_W-1:0] MSB_ONLY = {1'b1, {(CODE_W-1){1'b0}}};

  lock_state_t       state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d, trial;
  logic [BW-1:0]     bit_q, bit_d;
  logic              gate_q, gate_d;
  logic [LW-1:0]     alt_q, alt_d, same_q, same_d;
  logic              dir_q, dir_d;
  logic              locked_q, locked_d, err_q, err_d;
  logic [1:0]        sel_q;
  logic              busy_q;
  logic              tmr_load, ready;

  dcdl_settle_timer #(.SETTLE(SETTLE)) u_settle (
    .clk_ext (clk_ext),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .ready   (ready)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    bit_d    = bit_q;
    gate_d   = gate_q;
    alt_d    = alt_q;
    same_d   = same_q;
    dir_d    = dir_q;
    locked_d = locked_q;
    err_d    = err_q;
    tmr_load = 1'b0;
    trial    = code_q;

    if (start) begin
      // start outranks everything, including a coincident phase sample
      state_d  = GATE;
      code_d   = '0;
      gate_d   = 1'b0;
      locked_d = 1'b0;
      err_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        GATE: begin
          if (gate_q) begin
            state_d  = SAR;
            bit_d    = BW'(CODE_W - 1);
            code_d   = MSB_ONLY;
            tmr_load = 1'b1;
          end else begin
            gate_d = 1'b1;
          end
        end
        SAR: begin
          if (ready && pd_valid) begin
            if (!pd_up) trial[bit_q] = 1'b0;
            tmr_load = 1'b1;
            if (bit_q == '0) begin
              state_d = TRACK;
              code_d  = trial;
              alt_d   = '0;
              same_d  = '0;
            end else begin
              bit_d  = bit_q - 1'b1;
              code_d = trial | (CODE_W'(1) << (bit_q - 1'b1));
            end
          end
        end
        TRACK: begin
          if (ready && pd_valid) begin
            if ((pd_up && code_q == '1) || (!pd_up && code_q == '0)) begin
              err_d    = 1'b1;
              locked_d = 1'b0;
`ifdef DCDL_AUTO_RELOCK_EN
              state_d  = GATE;
              code_d   = '0;
              gate_d   = 1'b0;
`else
              state_d  = IDLE;
`endif
            end else begin
              code_d   = pd_up ? code_q + 1'b1 : code_q - 1'b1;
              tmr_load = 1'b1;
              dir_d    = pd_up;
              // alt_q == 0 marks the first tracking decision (no previous direction)
              if (alt_q == '0) begin
                alt_d  = LW'(1);
                same_d = '0;
              end else if (pd_up != dir_q) begin
                alt_d  = (alt_q == LW'(LOCK_CNT)) ? alt_q : alt_q + 1'b1;
                same_d = '0;
              end else begin
                alt_d  = LW'(1);
                same_d = (same_q == LW'(LOCK_CNT)) ? same_q : same_q + 1'b1;
              end
              if (!locked_q && alt_d == LW'(LOCK_CNT)) locked_d = 1'b1;
              if (locked_q && same_d == LW'(LOCK_CNT)) locked_d = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_ext) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      code_q   <= '0;
      bit_q    <= '0;
      gate_q   <= 1'b0;
      alt_q    <= '0;
      same_q   <= '0;
      dir_q    <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      sel_q    <= SEL_GATE;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      bit_q    <= bit_d;
      gate_q   <= gate_d;
      alt_q    <= alt_d;
      same_q   <= same_d;
      dir_q    <= dir_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      // select and busy come straight from flops so clk_mid switching never glitches
      sel_q    <= sel_of(state_d);
      busy_q   <= (state_d == GATE) || (state_d == SAR);
    end
  end

  assign q_code = code_q;
  assign sel    = sel_q;
  assign busy   = busy_q;
  assign locked = locked_q;
  assign err    = err_q;

endmodule
